// File: rtl/mac_mgnt_pkg.sv
// mac_mgnt_pkg: record layout, flag bit positions and handshake states shared with the management counter block
package mac_mgnt_pkg;
   localparam int MGNT_LEN_W = 12;
   localparam int MGNT_REC_W = 20;
   localparam int FLG_BP     = 19;
   localparam int FLG_JABBER = 18;
   localparam int FLG_RUNT   = 17;
   localparam int FLG_FCS    = 16;
   localparam int FLG_TTE    = 15;
   localparam int FLG_1588   = 14;
   localparam int FLG_FC     = 13;
   localparam int FLG_VLAN   = 12;
   typedef enum logic [3:0] {
      ST_IDLE = 4'b0001,
      ST_LOAD = 4'b0010,
      ST_REQ  = 4'b0100,
      ST_ACK  = 4'b1000
   } mgnt_state_t;
   // lengths above 12 bits saturate to 0xFFF rather than wrapping
   function automatic logic [MGNT_REC_W-1:0] mgnt_pack(input logic [15:0] len, input logic [7:0] flags);
      return {flags, (len > 16'h0FFF) ? 12'hFFF : len[MGNT_LEN_W-1:0]};
   endfunction
endpackage

// File: rtl/mac_mgnt_fifo.sv
// mac_mgnt_fifo: single-clock record FIFO with occupancy
//   clk, rst        clock, async active-high reset
//   wr_en, wr_data  push (caller guarantees room, or a same-cycle pop)
//   rd_en, rd_data  pop (caller guarantees non-empty); rd_data shows the head
//   full, empty, level  occupancy status
module mac_mgnt_fifo #(
   parameter int WIDTH = 20,
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     wr_en,
   input  logic [WIDTH-1:0]         wr_data,
   input  logic                     rd_en,
   output logic [WIDTH-1:0]         rd_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);
   localparam int AW = $clog2(DEPTH);
   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr, rd_ptr;
   always_ff @(posedge clk)
      if (wr_en) mem[wr_ptr] <= wr_data;
   // pointers wrap naturally because DEPTH is a power of two
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + 1'b1;
         if (rd_en) rd_ptr <= rd_ptr + 1'b1;
         level <= level + {{AW{1'b0}}, wr_en} - {{AW{1'b0}}, rd_en};
      end
   assign rd_data = mem[rd_ptr];
   assign full    = level == (AW+1)'(DEPTH);
   assign empty   = level == '0;
endmodule

// File: rtl/mac_rx_mgnt_report.sv
// mac_rx_mgnt_report: queues per-frame status records and hands them to the counter block over a 4-phase handshake
//   clk_if, rst_if                      RX MAC clock, async active-high reset
//   frm_done, frm_len, frm_flags        frame-end pulse with its length and flags
//   mgnt_valid, mgnt_data, mgnt_resp    4-phase handshake; mgnt_resp is asynchronous
//   drop_cnt                            saturating count of records lost to a full queue
//   q_level                             queue occupancy
module mac_rx_mgnt_report
   import mac_mgnt_pkg::*;
#(
   parameter int QUEUE_DEPTH    = 8,
   parameter int DROP_CNT_WIDTH = 16
) (
   input  logic                           clk_if,
   input  logic                           rst_if,
   input  logic                           frm_done,
   input  logic [15:0]                    frm_len,
   input  logic [7:0]                     frm_flags,
   output logic                           mgnt_valid,
   output logic [MGNT_REC_W-1:0]          mgnt_data,
   input  logic                           mgnt_resp,
   output logic [DROP_CNT_WIDTH-1:0]      drop_cnt,
   output logic [$clog2(QUEUE_DEPTH):0]   q_level
);
   (* ASYNC_REG = "TRUE" *) logic resp_m;
   (* ASYNC_REG = "TRUE" *) logic resp_s;
   mgnt_state_t           state, state_nx;
   logic [MGNT_REC_W-1:0] head;
   logic                  full, empty, pop, push;
   // a LOAD pop frees a slot, so a push in the same cycle is accepted even when full
   assign pop  = state == ST_LOAD;
   assign push = frm_done && (!full || pop);
   mac_mgnt_fifo #(.WIDTH(MGNT_REC_W), .DEPTH(QUEUE_DEPTH)) fifo (
      .clk     (clk_if),
      .rst     (rst_if),
      .wr_en   (push),
      .wr_data (mgnt_pack(frm_len, frm_flags)),
      .rd_en   (pop),
      .rd_data (head),
      .full    (full),
      .empty   (empty),
      .level   (q_level)
   );
   always_ff @(posedge clk_if or posedge rst_if)
      if (rst_if) begin
         resp_m <= 1'b0;
         resp_s <= 1'b0;
      end else begin
         resp_m <= mgnt_resp;
         resp_s <= resp_m;
      end
   always_comb begin
      state_nx = state;
      state_nx = state == ST_IDLE ? ((!empty && !resp_s) ? ST_LOAD : ST_IDLE) :
                 state == ST_LOAD ? ST_REQ :
                 state == ST_REQ  ? (resp_s ? ST_ACK : ST_REQ) :
                 state == ST_ACK  ? (resp_s ? ST_ACK : ST_IDLE) : ST_IDLE;
   end
   // mgnt_valid is registered so the crossing sees a glitch-free level
   always_ff @(posedge clk_if or posedge rst_if)
      if (rst_if) begin
         state      <= ST_IDLE;
         mgnt_valid <= 1'b0;
         mgnt_data  <= '0;
         drop_cnt   <= '0;
      end else begin
         state      <= state_nx;
         mgnt_valid <= state_nx == ST_REQ;
         if (pop) mgnt_data <= head;
         if (frm_done && !push && drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
      end
endmodule

// File: tb/tb_mac_rx_mgnt_report.sv
// tb_mac_rx_mgnt_report: scenario checks and a transaction-level scoreboard for mac_rx_mgnt_report
module tb_mac_rx_mgnt_report;
   localparam int DEPTH = 8;
   logic        clk_if = 1'b0;
   logic        rst_if = 1'b1;
   logic        frm_done = 1'b0;
   logic [15:0] frm_len = '0;
   logic [7:0]  frm_flags = '0;
   logic        mgnt_valid;
   logic [19:0] mgnt_data;
   logic        mgnt_resp = 1'b0;
   logic [15:0] drop_cnt;
   logic [3:0]  q_level;
   int total = 0;
   int bad = 0;
   logic [19:0] sb[$];
   int          occ = 0;
   int          m_drops = 0;
   logic        pv = 1'b0;
   logic        m_d, m_pop;
   logic [19:0] m_r;
   mac_rx_mgnt_report #(.QUEUE_DEPTH(DEPTH), .DROP_CNT_WIDTH(16)) dut (
      .clk_if     (clk_if),
      .rst_if     (rst_if),
      .frm_done   (frm_done),
      .frm_len    (frm_len),
      .frm_flags  (frm_flags),
      .mgnt_valid (mgnt_valid),
      .mgnt_data  (mgnt_data),
      .mgnt_resp  (mgnt_resp),
      .drop_cnt   (drop_cnt),
      .q_level    (q_level)
   );
   always #5 clk_if = ~clk_if;
   function automatic logic [19:0] model_rec(input logic [15:0] l, input logic [7:0] f);
      int n;
      n = int'(l);
      if (n > 4095) n = 4095;
      return {f, n[11:0]};
   endfunction
   // transaction model: a record leaves the queue on the edge where mgnt_valid rises
   always @(posedge clk_if) begin
      m_d = frm_done;
      m_r = model_rec(frm_len, frm_flags);
      #1;
      if (rst_if) begin
         occ = 0;
         pv  = 1'b0;
      end else begin
         m_pop = mgnt_valid && !pv;
         pv    = mgnt_valid;
         if (m_d) begin
            if (occ < DEPTH || m_pop) begin
               sb.push_back(m_r);
               occ++;
            end else if (m_drops < 65535) m_drops++;
         end
         if (m_pop) occ--;
      end
   end
   task automatic send(input logic [15:0] len, input logic [7:0] fl);
      frm_done  = 1'b1;
      frm_len   = len;
      frm_flags = fl;
      @(negedge clk_if);
      frm_done  = 1'b0;
   endtask
   task automatic deliver(input int dly);
      logic [19:0] want, got;
      int n;
      n = 0;
      while (!mgnt_valid && n < 300) begin
         @(negedge clk_if);
         n++;
      end
      total++;
      if (!mgnt_valid) begin
         bad++;
         $display("FAIL deliver_wait valid=%b required=1", mgnt_valid);
         return;
      end
      got  = mgnt_data;
      want = sb.size() != 0 ? sb.pop_front() : 20'hxxxxx;
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL deliver_data got=%05h required=%05h", got, want);
      end
      repeat (dly) @(negedge clk_if);
      mgnt_resp = 1'b1;
      n = 0;
      while (mgnt_valid && n < 20) begin
         @(negedge clk_if);
         n++;
      end
      total++;
      if (mgnt_valid !== 1'b0 || mgnt_data !== got) begin
         bad++;
         $display("FAIL deliver_ack valid=%b data=%05h required valid=0 data=%05h", mgnt_valid, mgnt_data, got);
      end
      mgnt_resp = 1'b0;
   endtask
   task automatic test_reset;
      repeat (2) @(negedge clk_if);
      total++;
      if (mgnt_valid !== 1'b0 || mgnt_data !== 20'h0 || drop_cnt !== 16'h0 || q_level !== 4'h0) begin
         bad++;
         $display("FAIL reset_values valid=%b data=%05h drop=%h level=%0d required all zero", mgnt_valid, mgnt_data, drop_cnt, q_level);
      end
      rst_if = 1'b0;
      repeat (3) @(negedge clk_if);
      total++;
      if (mgnt_valid !== 1'b0 || q_level !== 4'h0) begin
         bad++;
         $display("FAIL reset_idle valid=%b level=%0d required 0 0", mgnt_valid, q_level);
      end
   endtask
   task automatic test_single;
      logic [19:0] want;
      send(16'd64, 8'h10);
      @(negedge clk_if);
      total++;
      if (mgnt_valid !== 1'b0) begin
         bad++;
         $display("FAIL single_early valid=%b required=0", mgnt_valid);
      end
      @(negedge clk_if);
      total++;
      if (mgnt_valid !== 1'b1 || mgnt_data !== 20'h10040) begin
         bad++;
         $display("FAIL single_latency valid=%b data=%05h required 1 10040", mgnt_valid, mgnt_data);
      end
      want = sb.size() != 0 ? sb.pop_front() : 20'hxxxxx;
      total++;
      if (mgnt_data !== want) begin
         bad++;
         $display("FAIL single_scoreboard got=%05h required=%05h", mgnt_data, want);
      end
      repeat (5) @(negedge clk_if);
      mgnt_resp = 1'b1;
      repeat (2) @(negedge clk_if);
      total++;
      if (mgnt_valid !== 1'b1) begin
         bad++;
         $display("FAIL single_ack_early valid=%b required=1", mgnt_valid);
      end
      @(negedge clk_if);
      total++;
      if (mgnt_valid !== 1'b0 || mgnt_data !== 20'h10040) begin
         bad++;
         $display("FAIL single_ack valid=%b data=%05h required 0 10040", mgnt_valid, mgnt_data);
      end
      mgnt_resp = 1'b0;
      repeat (6) @(negedge clk_if);
      total++;
      if (mgnt_valid !== 1'b0 || q_level !== 4'h0) begin
         bad++;
         $display("FAIL single_idle valid=%b level=%0d required 0 0", mgnt_valid, q_level);
      end
   endtask
   task automatic test_len_sat;
      send(16'h1234, 8'h40);
      repeat (2) @(negedge clk_if);
      total++;
      if (mgnt_valid !== 1'b1 || mgnt_data !== 20'h40FFF) begin
         bad++;
         $display("FAIL len_sat valid=%b data=%05h required 1 40FFF", mgnt_valid, mgnt_data);
      end
      deliver(2);
      repeat (6) @(negedge clk_if);
   endtask
   task automatic test_overflow;
      logic [19:0] want;
      int n;
      for (int i = 0; i < 10; i++) send(16'(100 + i), 8'($urandom));
      total++;
      if (q_level !== 4'd8 || drop_cnt !== 16'd1 || mgnt_valid !== 1'b1 || mgnt_data[11:0] !== 12'd100) begin
         bad++;
         $display("FAIL overflow level=%0d drop=%0d valid=%b len=%0d required 8 1 1 100", q_level, drop_cnt, mgnt_valid, mgnt_data[11:0]);
      end
      want = sb.size() != 0 ? sb.pop_front() : 20'hxxxxx;
      total++;
      if (mgnt_data !== want) begin
         bad++;
         $display("FAIL overflow_head got=%05h required=%05h", mgnt_data, want);
      end
      mgnt_resp = 1'b1;
      n = 0;
      while (mgnt_valid && n < 10) begin
         @(negedge clk_if);
         n++;
      end
      mgnt_resp = 1'b0;
      repeat (4) @(negedge clk_if);
      total++;
      if (mgnt_valid !== 1'b0 || q_level !== 4'd8) begin
         bad++;
         $display("FAIL overflow_gap valid=%b level=%0d required 0 8", mgnt_valid, q_level);
      end
      // this push lands on the same edge as the next pop
      send(16'h00AA, 8'h81);
      total++;
      if (mgnt_valid !== 1'b1 || q_level !== 4'd8 || drop_cnt !== 16'd1) begin
         bad++;
         $display("FAIL full_pop valid=%b level=%0d drop=%0d required 1 8 1", mgnt_valid, q_level, drop_cnt);
      end
      for (int i = 0; i < 9; i++) deliver(1);
      repeat (6) @(negedge clk_if);
      total++;
      if (q_level !== 4'd0 || mgnt_valid !== 1'b0) begin
         bad++;
         $display("FAIL overflow_drain level=%0d valid=%b required 0 0", q_level, mgnt_valid);
      end
   endtask
   task automatic test_random;
      bit tr_done;
      int guard;
      tr_done = 1'b0;
      fork
         begin
            for (int i = 0; i < 400; i++) begin
               frm_done  = $urandom_range(0, 3) == 0;
               frm_len   = 16'($urandom_range(0, 1) != 0 ? $urandom_range(0, 8191) : $urandom_range(0, 65535));
               frm_flags = 8'($urandom);
               @(negedge clk_if);
            end
            frm_done = 1'b0;
            tr_done  = 1'b1;
         end
         begin
            guard = 0;
            while ((!tr_done || sb.size() != 0) && guard < 3000) begin
               guard++;
               if (sb.size() == 0) @(negedge clk_if);
               else deliver($urandom_range(1, 20));
            end
         end
      join
      repeat (6) @(negedge clk_if);
      total++;
      if (q_level !== 4'd0 || drop_cnt !== 16'(m_drops) || sb.size() != 0) begin
         bad++;
         $display("FAIL random_end level=%0d drop=%0d left=%0d required 0 %0d 0", q_level, drop_cnt, sb.size(), m_drops);
      end
   endtask
   task automatic test_drop_sat;
      frm_done  = 1'b1;
      frm_len   = 16'd60;
      frm_flags = 8'h02;
      repeat (65560) @(negedge clk_if);
      frm_done = 1'b0;
      @(negedge clk_if);
      total++;
      if (drop_cnt !== 16'hFFFF || q_level !== 4'd8 || mgnt_valid !== 1'b1) begin
         bad++;
         $display("FAIL drop_sat drop=%h level=%0d valid=%b required FFFF 8 1", drop_cnt, q_level, mgnt_valid);
      end
   endtask
   task automatic test_reset_mid;
      bit quiet;
      #2 rst_if = 1'b1;
      sb.delete();
      m_drops = 0;
      #1;
      total++;
      if (mgnt_valid !== 1'b0 || q_level !== 4'd0 || drop_cnt !== 16'd0 || mgnt_data !== 20'h0) begin
         bad++;
         $display("FAIL reset_async_full valid=%b level=%0d drop=%h data=%05h required all zero", mgnt_valid, q_level, drop_cnt, mgnt_data);
      end
      @(negedge clk_if);
      rst_if = 1'b0;
      @(negedge clk_if);
      for (int i = 0; i < 4; i++) send(16'(200 + i), 8'h08);
      total++;
      if (q_level !== 4'd3 || mgnt_valid !== 1'b1) begin
         bad++;
         $display("FAIL reset_setup level=%0d valid=%b required 3 1", q_level, mgnt_valid);
      end
      #2 rst_if = 1'b1;
      sb.delete();
      #1;
      total++;
      if (mgnt_valid !== 1'b0 || q_level !== 4'd0 || drop_cnt !== 16'd0) begin
         bad++;
         $display("FAIL reset_mid valid=%b level=%0d drop=%0d required 0 0 0", mgnt_valid, q_level, drop_cnt);
      end
      @(negedge clk_if);
      rst_if = 1'b0;
      quiet = 1'b1;
      repeat (20) begin
         @(negedge clk_if);
         if (mgnt_valid !== 1'b0 || q_level !== 4'd0) quiet = 1'b0;
      end
      total++;
      if (!quiet) begin
         bad++;
         $display("FAIL reset_quiet valid=%b level=%0d required 0 0", mgnt_valid, q_level);
      end
      send(16'h0020, 8'h01);
      repeat (2) @(negedge clk_if);
      total++;
      if (mgnt_valid !== 1'b1 || mgnt_data !== 20'h01020) begin
         bad++;
         $display("FAIL reset_new_frame valid=%b data=%05h required 1 01020", mgnt_valid, mgnt_data);
      end
   endtask
   initial begin
      test_reset;
      test_single;
      test_len_sat;
      test_overflow;
      test_random;
      test_drop_sat;
      test_reset_mid;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
